// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
//   state_e : FSM state encoding
//   OP_*    : supported instr[31:26] opcodes
//   ALUOP_* : ALU operation class handed to the ALU control decoder
//   SRCB_*  : ALU B operand select
//   PCSRC_* : next-PC select
//   ctrl_t  : raw per-state control word, before mem_ready / reset gating
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       retire;
    logic       gate_rdy;  // ir_write/pc_write/retire only fire with mem_ready
  } ctrl_t;

  function automatic logic opcode_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Purely combinational state -> control word decode (Moore part).
//   state_i : current FSM state
//   ctrl_o  : raw control word; handshake and reset gating live in the top
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.gate_rdy  = 1'b1;
      end
      S_DECODE: ctrl_o.alu_src_b = SRCB_IMMSH;  // branch target into ALUOut
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMRD:  ctrl_o.iord = 1'b1;
      S_MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.retire    = 1'b1;
        ctrl_o.gate_rdy  = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.branch    = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_src   = PCSRC_JUMP;
        ctrl_o.pc_write = 1'b1;
        ctrl_o.retire   = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   opcode, zero          : instr[31:26] and ALU zero flag
//   mem_ready             : memory access completes this cycle
//   iord..pc_src          : datapath selects and write enables
//   pc_en                 : pc_write | (branch & zero)
//   retire, illegal_op    : one-cycle completion / bad-opcode pulses
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       retire,
  output logic       illegal_op
);

  state_e state_q, state_d;
  ctrl_t  cw;
  logic   rdy_ok;
  logic   pc_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // IR is stable here, so re-examining opcode picks the LW/SW leg
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR :
                          (opcode == OP_LW) ? S_MEMRD : S_FETCH;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (cw)
  );

  // Handshake-gated strobes only fire in the cycle the memory completes.
  assign rdy_ok   = ~cw.gate_rdy | mem_ready;
  assign pc_write = cw.pc_write & rdy_ok;

  // Selects follow the state (FETCH during reset); strobes are also
  // forced low combinationally while rst_n is held.
  assign iord       = cw.iord;
  assign reg_dst    = cw.reg_dst;
  assign mem_to_reg = cw.mem_to_reg;
  assign alu_src_a  = cw.alu_src_a;
  assign alu_src_b  = cw.alu_src_b;
  assign alu_op     = cw.alu_op;
  assign pc_src     = cw.pc_src;
  assign mem_write  = rst_n & cw.mem_write;
  assign ir_write   = rst_n & cw.ir_write & rdy_ok;
  assign reg_write  = rst_n & cw.reg_write;
  assign pc_en      = rst_n & (pc_write | (cw.branch & zero));
  assign retire     = rst_n & cw.retire & rdy_ok;
  assign illegal_op = rst_n & (state_q == S_DECODE) & ~opcode_legal(opcode);

endmodule
